// File: rtl/core_mc.sv
// core_mc: multi-cycle core (FETCH -> EXEC [-> MEM]) executing the 32-bit
// single-cycle instruction format, with a req/ack data memory port.
// Optional feature macro: CORE_MC_LINK_EN enables jump-and-link and
// register-sourced jump targets.
module core_mc #(
    parameter int DW   = 32,
    parameter int NREG = 16,
    parameter int PAW  = 8,
    parameter int DAW  = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    output logic [PAW-1:0] pmem_addr_o,
    input  logic [31:0]    pmem_dt_i,
    output logic           dmem_req_o,
    input  logic           dmem_ack_i,
    output logic           dmem_wr_o,
    output logic [DAW-1:0] dmem_addr_o,
    output logic [DW-1:0]  dmem_dt_o,
    input  logic [DW-1:0]  dmem_dt_i
);

    localparam int RIW = $clog2(NREG);
    localparam int SHW = $clog2(DW);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;

    logic [1:0]     state_q;
    logic [31:0]    ir_q;
    logic [PAW-1:0] pc_q;
    logic           z_q;
    logic           s_q;
    logic [DW-1:0]  rf_q [NREG];

    // Instruction fields
    logic           reg_we, mem_we, pc_we, flg_we, alu_src, reg_src;
    logic [2:0]     cond, alu_op;
    logic [7:0]     lit;
    logic [RIW-1:0] rd_idx, rsa_idx, rsb_idx;

    assign reg_we  = ir_q[31];
    assign mem_we  = ir_q[30];
    assign pc_we   = ir_q[29];
    assign flg_we  = ir_q[28];
    assign alu_src = ir_q[27];
    assign reg_src = ir_q[26];
    assign cond    = ir_q[25:23];
    assign alu_op  = ir_q[22:20];
    assign lit     = ir_q[19:12];
    assign rsb_idx = ir_q[8 +: RIW];
    assign rsa_idx = ir_q[4 +: RIW];
    assign rd_idx  = ir_q[0 +: RIW];

    function automatic logic [DW-1:0] alu_f(input logic [2:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            3'd0:    alu_f = a + b;
            3'd1:    alu_f = a - b;
            3'd2:    alu_f = a & b;
            3'd3:    alu_f = a | b;
            3'd4:    alu_f = a ^ b;
            3'd5:    alu_f = a << b[SHW-1:0];
            3'd6:    alu_f = a >> b[SHW-1:0];
            default: alu_f = b;
        endcase
    endfunction

    function automatic logic cond_f(input logic [2:0] c, input logic z, input logic s);
        case (c)
            3'd1:    cond_f = z;
            3'd2:    cond_f = !z;
            3'd3:    cond_f = s;
            3'd4:    cond_f = !s;
            default: cond_f = 1'b1;
        endcase
    endfunction

    logic [DW-1:0]  rsa_val, rsb_val, alu_b, alu_res, wb_data;
    logic [PAW-1:0] pc_inc, jmp_tgt, pc_nxt;
    logic           is_mem, done, link, wb_en;

    assign rsa_val = rf_q[rsa_idx];
    assign rsb_val = rf_q[rsb_idx];
    assign alu_b   = alu_src ? DW'(lit) : rsb_val;
    assign alu_res = alu_f(alu_op, rsa_val, alu_b);
    assign pc_inc  = pc_q + PAW'(1);

`ifdef CORE_MC_LINK_EN
    assign link    = pc_we & reg_we & !reg_src;
    assign jmp_tgt = (!alu_src && (rsb_idx != '0)) ? PAW'(rsb_val) : PAW'(lit);
`else
    assign link    = 1'b0;
    assign jmp_tgt = PAW'(lit);
`endif

    assign pc_nxt  = (pc_we && cond_f(cond, z_q, s_q)) ? jmp_tgt : pc_inc;
    assign is_mem  = mem_we | reg_src;
    // An instruction retires at the end of EXEC (no memory) or on the MEM ack.
    assign done    = ((state_q == S_EXEC) && !is_mem) || ((state_q == S_MEM) && dmem_ack_i);
    // Stores never write back unless the link path claims the write.
    assign wb_en   = done && reg_we && (!is_mem || reg_src || link);
    assign wb_data = reg_src ? dmem_dt_i : (link ? DW'(pc_inc) : alu_res);

    assign pmem_addr_o = pc_q;
    assign dmem_req_o  = (state_q == S_MEM);
    assign dmem_wr_o   = (state_q == S_MEM) && mem_we;
    assign dmem_addr_o = DAW'(rsb_val) + DAW'(lit);
    assign dmem_dt_o   = rsa_val;

    // Sequencing: state machine, instruction register, PC and flags
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            pc_q    <= '0;
            z_q     <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_q    <= pmem_dt_i;
                    state_q <= S_EXEC;
                end
                S_EXEC:  state_q <= is_mem ? S_MEM : S_FETCH;
                S_MEM:   if (dmem_ack_i) state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
            if (done) begin
                pc_q <= pc_nxt;
                if (flg_we) begin
                    z_q <= (alu_res == '0);
                    s_q <= alu_res[DW-1];
                end
            end
        end
    end

    // Register file: single write port, written when an instruction retires
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_en) begin
            rf_q[rd_idx] <= wb_data;
        end
    end

endmodule
